// File: rtl/game_round_ctrl_pkg.sv
// Shared types and helpers for the game round sequencer.
package game_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GENERATE,
    ST_SETTLE,
    ST_SHOW,
    ST_RESULT,
    ST_GAME_OVER
  } state_t;

  localparam logic [1:0] LVL_BEGINNER     = 2'd0;
  localparam logic [1:0] LVL_INTERMEDIATE = 2'd1;
  localparam logic [1:0] LVL_ADVANCED     = 2'd2;
  localparam logic [1:0] LVL_BEGINNER_ALT = 2'd3;

  localparam logic [7:0] SCORE_MAX = 8'd255;

  // Response window length in ticks for a difficulty level.
  function automatic logic [7:0] win_ticks(input logic [1:0]  lvl,
                                           input int unsigned w_beg,
                                           input int unsigned w_int,
                                           input int unsigned w_adv);
    logic [7:0] w;
    case (lvl)
      LVL_INTERMEDIATE: w = 8'(w_int);
      LVL_ADVANCED:     w = 8'(w_adv);
      LVL_BEGINNER,
      LVL_BEGINNER_ALT: w = 8'(w_beg);
      default:          w = 8'(w_beg);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Game-side signal bundle between the sequencer and its environment.
interface game_round_ctrl_if;
  logic       Start;
  logic [1:0] Level;
  logic [3:0] Rand_Num;
  logic       Rand_Time_Out;
  logic [3:0] Guess;
  logic       Submit;
  logic       Rand_Enable;
  logic [3:0] Target;
  logic       Target_Valid;
  logic       Hit;
  logic       Miss;
  logic [7:0] Score;
  logic [1:0] Lives;
  logic       Game_Over;

  modport master (
    output Start, Level, Rand_Num, Rand_Time_Out, Guess, Submit,
    input  Rand_Enable, Target, Target_Valid, Hit, Miss, Score, Lives, Game_Over
  );

  modport slave (
    input  Start, Level, Rand_Num, Rand_Time_Out, Guess, Submit,
    output Rand_Enable, Target, Target_Valid, Hit, Miss, Score, Lives, Game_Over
  );
endinterface

// File: rtl/game_round_ctrl_round_tick_prescaler.sv
// Response-window prescaler: one-cycle tick every TICK_DIV cycles while not cleared.
module round_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick = w_wrap && !i_clear;

  // Cycle counter, held at zero while cleared so counting starts on the first live cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                r_cnt <= '0;
    else if (i_clear || w_wrap) r_cnt <= '0;
    else                        r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the reaction/guess game.
// Optional macro REPEAT_REROLL_EN: reject a capture equal to the previous round's target.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int unsigned GEN_CYCLES       = 5,
  parameter int unsigned TICK_DIV         = 50000000,
  parameter int unsigned WIN_BEGINNER     = 8,
  parameter int unsigned WIN_INTERMEDIATE = 5,
  parameter int unsigned WIN_ADVANCED     = 3,
  parameter int unsigned LIVES_INIT       = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  game_round_ctrl_if.slave bus
);
  state_t     r_state, w_state_nxt;
  logic [1:0] r_level, w_level_nxt;
  logic [7:0] r_gen_cnt, w_gen_nxt;
  logic [7:0] r_win_cnt, w_win_nxt;
  logic [3:0] r_target, w_target_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic       r_hit, w_hit_nxt;
  logic       r_miss, w_miss_nxt;
  logic       r_rand_en, r_tval, r_game_over;
  logic       w_tick, w_expire, w_start, w_repeat, w_presc_clr;
  logic [7:0] w_win_len;

  assign w_start     = ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER)) && bus.Start;
  assign w_win_len   = win_ticks(r_level, WIN_BEGINNER, WIN_INTERMEDIATE, WIN_ADVANCED);
  assign w_expire    = w_tick && (r_win_cnt == w_win_len - 8'd1);
  assign w_presc_clr = (r_state != ST_SHOW);

  round_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_clear (w_presc_clr),
    .o_tick  (w_tick)
  );

`ifdef REPEAT_REROLL_EN
  logic r_have_prev;
  // Tracks whether r_target already holds a target from the current game.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)       r_have_prev <= 1'b0;
    else if (w_start) r_have_prev <= 1'b0;
    else if ((r_state == ST_SETTLE) && bus.Rand_Time_Out && !w_repeat)
      r_have_prev <= 1'b1;
  end
  assign w_repeat = r_have_prev && (bus.Rand_Num == r_target);
`else
  assign w_repeat = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: if (bus.Start) w_state_nxt = ST_GENERATE;
      ST_GENERATE:           if (r_gen_cnt == '0) w_state_nxt = ST_SETTLE;
      ST_SETTLE:             if (bus.Rand_Time_Out)
                               w_state_nxt = w_repeat ? ST_GENERATE : ST_SHOW;
      ST_SHOW:               if (bus.Submit || w_expire) w_state_nxt = ST_RESULT;
      ST_RESULT:             w_state_nxt = (r_lives == '0) ? ST_GAME_OVER : ST_GENERATE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of counters and registered outputs; the generate counter counts down
  // so a reroll can reuse it by loading zero for a single extra enable cycle.
  always_comb begin
    w_level_nxt  = r_level;
    w_gen_nxt    = r_gen_cnt;
    w_win_nxt    = '0;
    w_target_nxt = r_target;
    w_score_nxt  = r_score;
    w_lives_nxt  = r_lives;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.Start) begin
          w_level_nxt = bus.Level;
          w_score_nxt = '0;
          w_lives_nxt = 2'(LIVES_INIT);
          w_gen_nxt   = 8'(GEN_CYCLES - 1);
        end
      end
      ST_GENERATE: begin
        if (r_gen_cnt != '0) w_gen_nxt = r_gen_cnt - 8'd1;
      end
      ST_SETTLE: begin
        if (bus.Rand_Time_Out) begin
          if (w_repeat) w_gen_nxt    = '0;
          else          w_target_nxt = bus.Rand_Num;
        end
      end
      ST_SHOW: begin
        w_win_nxt = w_tick ? (r_win_cnt + 8'd1) : r_win_cnt;
        if (bus.Submit) begin
          if (bus.Guess == r_target) begin
            w_hit_nxt = 1'b1;
            if (r_score != SCORE_MAX) w_score_nxt = r_score + 8'd1;
          end else begin
            w_miss_nxt = 1'b1;
            if (r_lives != '0) w_lives_nxt = r_lives - 2'd1;
          end
        end else if (w_expire) begin
          w_miss_nxt = 1'b1;
          if (r_lives != '0) w_lives_nxt = r_lives - 2'd1;
        end
      end
      ST_RESULT: begin
        if (r_lives != '0) w_gen_nxt = 8'(GEN_CYCLES - 1);
      end
      default: ;
    endcase
  end

  // Output and datapath registers; state-decoded outputs follow the next state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_level     <= '0;
      r_gen_cnt   <= '0;
      r_win_cnt   <= '0;
      r_target    <= '0;
      r_score     <= '0;
      r_lives     <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_rand_en   <= 1'b0;
      r_tval      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_level     <= w_level_nxt;
      r_gen_cnt   <= w_gen_nxt;
      r_win_cnt   <= w_win_nxt;
      r_target    <= w_target_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_rand_en   <= (w_state_nxt == ST_GENERATE);
      r_tval      <= (w_state_nxt == ST_SHOW);
      r_game_over <= (w_state_nxt == ST_GAME_OVER);
    end
  end

  assign bus.Rand_Enable  = r_rand_en;
  assign bus.Target       = r_target;
  assign bus.Target_Valid = r_tval;
  assign bus.Hit          = r_hit;
  assign bus.Miss         = r_miss;
  assign bus.Score        = r_score;
  assign bus.Lives        = r_lives;
  assign bus.Game_Over    = r_game_over;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl with a modelled random-number stage.
module tb_game_round_ctrl;
  localparam int unsigned GEN_CYCLES = 5;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned LIVES_INIT = 3;
`ifdef REPEAT_REROLL_EN
  localparam bit REROLL = 1'b1;
`else
  localparam bit REROLL = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_GEN = 1, PH_SETTLE = 2, PH_SHOW = 3, PH_RESULT = 4, PH_OVER = 5;

  logic clk = 1'b0;
  logic rst_n;
  game_round_ctrl_if bus();

  game_round_ctrl #(
    .GEN_CYCLES(GEN_CYCLES), .TICK_DIV(TICK_DIV), .WIN_BEGINNER(8),
    .WIN_INTERMEDIATE(5), .WIN_ADVANCED(3), .LIVES_INIT(LIVES_INIT)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Random-number stage: value steps once per enabled cycle, Time_Out is a registered !Enable.
  logic [3:0] rv [128];
  int unsigned en_cnt = 0;
  initial begin
    logic en_now;
    for (int i = 0; i < 128; i++) rv[i] = 4'((7 * i + 1) % 16);
    rv[5]  = 4'h9;
    rv[25] = 4'h6;
    rv[30] = 4'h6;
    rv[31] = 4'hC;
    bus.Rand_Num      = rv[0];
    bus.Rand_Time_Out = 1'b1;
    forever begin
      @(negedge clk);
      en_now = bus.Rand_Enable;
      @(posedge clk);
      #1;
      if (en_now) en_cnt++;
      bus.Rand_Num      = rv[en_cnt % 128];
      bus.Rand_Time_Out = !en_now;
    end
  end

  // Game model: phases with remaining-cycle budgets derived from the game rules.
  int unsigned wtab [4] = '{8, 5, 3, 8};
  int   m_phase = PH_IDLE;
  int   m_left = 0, m_w = 0, m_score = 0, m_lives = 0;
  logic [3:0] m_target = '0;
  bit   m_hit = 0, m_miss = 0, m_prev_ok = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_left = 0; m_target = '0; m_score = 0; m_lives = 0;
      m_hit = 0; m_miss = 0; m_prev_ok = 0;
    end else begin
      chk("Rand_Enable",  bus.Rand_Enable,  (m_phase == PH_GEN));
      chk("Target_Valid", bus.Target_Valid, (m_phase == PH_SHOW));
      chk("Game_Over",    bus.Game_Over,    (m_phase == PH_OVER));
      chk("Hit",          bus.Hit,          m_hit);
      chk("Miss",         bus.Miss,         m_miss);
      chk("Score",        bus.Score,        m_score);
      chk("Lives",        bus.Lives,        m_lives);
      chk("Target",       bus.Target,       m_target);
      m_hit = 0;
      m_miss = 0;
      case (m_phase)
        PH_IDLE, PH_OVER: if (bus.Start) begin
          m_w = wtab[bus.Level] * TICK_DIV;
          m_score = 0; m_lives = LIVES_INIT; m_prev_ok = 0;
          m_left = GEN_CYCLES; m_phase = PH_GEN;
        end
        PH_GEN: begin
          m_left--;
          if (m_left == 0) m_phase = PH_SETTLE;
        end
        PH_SETTLE: if (bus.Rand_Time_Out) begin
          if (REROLL && m_prev_ok && bus.Rand_Num == m_target) begin
            m_left = 1; m_phase = PH_GEN;
          end else begin
            m_target = bus.Rand_Num; m_prev_ok = 1; m_left = m_w; m_phase = PH_SHOW;
          end
        end
        PH_SHOW: begin
          if (bus.Submit) begin
            if (bus.Guess == m_target) begin
              m_hit = 1;
              if (m_score < 255) m_score++;
            end else begin
              m_miss = 1; m_lives--;
            end
            m_phase = PH_RESULT;
          end else if (m_left == 1) begin
            m_miss = 1; m_lives--; m_phase = PH_RESULT;
          end else begin
            m_left--;
          end
        end
        PH_RESULT: begin
          if (m_lives == 0) m_phase = PH_OVER;
          else begin m_left = GEN_CYCLES; m_phase = PH_GEN; end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [1:0] lvl);
    bus.Level = lvl;
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
  endtask

  task automatic run_to_show(output int n_en, output bit ok);
    n_en = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.Target_Valid) begin ok = 1; break; end
      if (bus.Rand_Enable) n_en++;
      cyc();
    end
  endtask

  task automatic wait_miss(input int n0, output int n);
    n = n0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (bus.Miss) break;
    end
  endtask

  task automatic miss_round(input string tag, input int exp_delay, input int exp_lives);
    int n_en, n;
    bit ok;
    run_to_show(n_en, ok);
    chk({tag, " show reached"}, ok, 1);
    wait_miss(0, n);
    chk({tag, " miss delay"}, n, exp_delay);
    chk({tag, " lives"}, bus.Lives, exp_lives);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_en, n;
    bit ok;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.Level = 2'd0; bus.Guess = 4'h0; bus.Submit = 1'b0;
    repeat (3) cyc();
    chk("rst Rand_Enable", bus.Rand_Enable, 0);
    chk("rst Target_Valid", bus.Target_Valid, 0);
    chk("rst Lives", bus.Lives, 0);
    chk("rst Score", bus.Score, 0);
    chk("rst Game_Over", bus.Game_Over, 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Game A, Beginner: hit, miss with submit on expiry, two timeouts
    start_game(2'd0);
    chk("A start lives", bus.Lives, 3);
    chk("A start score", bus.Score, 0);
    run_to_show(n_en, ok);
    chk("A1 show reached", ok, 1);
    chk("A1 enable cycles", n_en, 5);
    chk("A1 target", bus.Target, 4'h9);
    cyc(); cyc();
    bus.Guess = 4'h9; bus.Submit = 1'b1;
    cyc();
    bus.Submit = 1'b0;
    chk("A1 hit", bus.Hit, 1);
    chk("A1 score", bus.Score, 1);
    cyc();
    chk("A1 hit pulse end", bus.Hit, 0);
    chk("A1 next generate", bus.Rand_Enable, 1);

    run_to_show(n_en, ok);
    chk("A2 show reached", ok, 1);
    repeat (31) cyc();
    bus.Guess = m_target ^ 4'hF; bus.Submit = 1'b1;
    cyc();
    bus.Submit = 1'b0;
    chk("A2 miss", bus.Miss, 1);
    chk("A2 no hit", bus.Hit, 0);
    chk("A2 lives", bus.Lives, 2);
    cyc();
    chk("A2 miss pulse end", bus.Miss, 0);
    bus.Guess = 4'h0; bus.Submit = 1'b1;
    cyc();
    bus.Submit = 1'b0;
    miss_round("A3", 32, 1);
    miss_round("A4", 32, 0);
    cyc();
    chk("A game over", bus.Game_Over, 1);
    chk("A held score", bus.Score, 1);
    chk("A held lives", bus.Lives, 0);

    // Game B, Advanced: repeat capture and level change mid-game
    start_game(2'd2);
    chk("B start lives", bus.Lives, 3);
    chk("B start score", bus.Score, 0);
    chk("B game over clear", bus.Game_Over, 0);
    run_to_show(n_en, ok);
    chk("B1 show reached", ok, 1);
    chk("B1 target", bus.Target, 4'h6);
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    wait_miss(1, n);
    chk("B1 miss delay", n, 12);
    chk("B1 lives", bus.Lives, 2);
    bus.Level = 2'd1;
    run_to_show(n_en, ok);
    chk("B2 show reached", ok, 1);
    chk("B2 enable cycles", n_en, REROLL ? 6 : 5);
    chk("B2 target", bus.Target, REROLL ? 4'hC : 4'h6);
    wait_miss(0, n);
    chk("B2 miss delay", n, 12);
    chk("B2 lives", bus.Lives, 1);
    miss_round("B3", 12, 0);
    cyc();
    chk("B game over", bus.Game_Over, 1);

    // Game C, Intermediate
    start_game(2'd1);
    miss_round("C1", 20, 2);
    miss_round("C2", 20, 1);
    miss_round("C3", 20, 0);
    cyc();
    chk("C game over", bus.Game_Over, 1);

    // Game D, Level 3 behaves as Beginner; reset lands mid-SHOW
    start_game(2'd3);
    miss_round("D1", 32, 2);
    run_to_show(n_en, ok);
    chk("D2 show reached", ok, 1);
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst Target_Valid", bus.Target_Valid, 0);
    chk("mid rst Lives", bus.Lives, 0);
    chk("mid rst Score", bus.Score, 0);
    chk("mid rst Rand_Enable", bus.Rand_Enable, 0);
    chk("mid rst Game_Over", bus.Game_Over, 0);
    chk("mid rst Miss", bus.Miss, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("post rst idle enable", bus.Rand_Enable, 0);
    chk("post rst idle valid", bus.Target_Valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the reaction/guess game. Sits directly downstream of the 4-bit LFSR random-number stage and drives that stage's Enable input.
- Each round:
  - Run the generator for a fixed number of cycles, then freeze it.
  - Latch its 4-bit value as the round target.
  - Open a level-dependent response window for the player's 4-bit guess.
  - Score hits, count down lives on misses, and end the game at zero lives.

Parameters:
- GEN_CYCLES, 5: clock cycles Rand_Enable is held high per round (1..255).
- TICK_DIV, 50000000: clock cycles per response-window tick (>=2).
- WIN_BEGINNER, 8: response window in ticks at Level 0 (and Level 3).
- WIN_INTERMEDIATE, 5: response window in ticks at Level 1.
- WIN_ADVANCED, 3: response window in ticks at Level 2.
- LIVES_INIT, 3: lives at game start (1..3).

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; starts a game from IDLE or GAME_OVER.
- Level  in  2  difficulty: 0 Beginner, 1 Intermediate, 2 Advanced, 3 = Beginner.
- Rand_Num  in  4  Q from the random-number stage.
- Rand_Time_Out  in  1  Time_Out from the random-number stage (1 = generator frozen).
- Guess  in  4  player switch value.
- Submit  in  1  debounced one-cycle pulse; player commits Guess.
- Rand_Enable  out  1  Enable to the random-number stage.
- Target  out  4  latched round target.
- Target_Valid  out  1  high while in SHOW.
- Hit  out  1  one-cycle pulse on a correct guess.
- Miss  out  1  one-cycle pulse on a wrong guess or window expiry.
- Score  out  8  hits this game, saturating.
- Lives  out  2  remaining lives.
- Game_Over  out  1  high in GAME_OVER.

Behaviour:
- Reset: Reset=0 asynchronously forces IDLE and clears every output and counter, including Lives, regardless of the current state.
- States: IDLE, GENERATE, SETTLE, SHOW, RESULT, GAME_OVER. All outputs are registered.
- IDLE:
  - On Start, sample Level into an internal register (held for the whole game).
  - Score<=0, Lives<=LIVES_INIT, then go to GENERATE.
- GENERATE:
  - Rand_Enable=1 for exactly GEN_CYCLES consecutive cycles (cycle counter), then go to SETTLE.
- SETTLE:
  - Rand_Enable=0. Wait until Rand_Time_Out==1.
  - In that cycle: Target<=Rand_Num, then go to SHOW.
  - The wait has no timeout.
- SHOW:
  - Target_Valid=1.
  - On entry, the prescaler and window counter are cleared. Expiry occurs exactly W*TICK_DIV cycles after the first SHOW cycle; W is chosen by the latched Level.
  - Submit with Guess==Target: Hit pulse; Score<=Score+1, saturating at 255.
  - Submit with Guess!=Target, or window expiry: Miss pulse; Lives<=Lives-1.
  - Submit and expiry in the same cycle: Submit wins.
  - Either outcome goes to RESULT.
- RESULT (1 cycle): if Lives==0 go to GAME_OVER, else go to GENERATE.
- GAME_OVER:
  - Game_Over=1. Score, Target and Lives are held.
  - Start clears Game_Over and re-enters the IDLE start actions in the same transition.
- Ignored inputs:
  - Submit outside SHOW is ignored.
  - Start outside IDLE/GAME_OVER is ignored.
  - Level changes take effect only at the next game start.
- Hit and Miss are mutually exclusive and never asserted in the same cycle.

Optional Feature:
- Macro: REPEAT_REROLL_EN.
- Defined: in SETTLE, if Rand_Num equals the previous round's Target (not the first round of a game), do not latch. Instead return to GENERATE for one extra cycle of Rand_Enable=1, then SETTLE again; repeat until the value differs.
- Undefined: the first SETTLE capture is always accepted, repeats allowed.

Decomposition:
- Shared package: state encoding, Level encoding constants, a window-select function (Level to ticks), and the score saturation limit.
- One natural sub-module, round_tick_prescaler: clear input, TICK_DIV counter, one-cycle tick output.

Test Plan:
- Directed runs use TICK_DIV=4 and GEN_CYCLES=5 unless noted; the bench models the random-number stage.
- Reset=0 mid-SHOW -> same cycle: Target_Valid=0, Lives=0, Score=0, state IDLE; Rand_Enable=0.
- Start, Level=0 -> Rand_Enable high exactly 5 cycles; after Rand_Time_Out=1, Target equals the model value, Target_Valid=1.
- Target=4'h9, Submit with Guess=4'h9 at SHOW cycle 3 -> Hit one cycle, Score 0->1; next round GENERATE starts 2 cycles later.
- Level=2, no Submit -> Miss exactly 12 cycles after SHOW entry, Lives 3->2. Repeat for Level=1 (20 cycles) and Level=3 (32 cycles).
- Submit with wrong Guess in the same cycle as expiry -> a single Miss, Lives decremented once. Three misses -> Game_Over=1, Score held; Start -> Lives=3, Score=0.
- REPEAT_REROLL_EN defined, model returns the same value twice -> one extra Rand_Enable cycle, Target differs from the previous round. Undefined -> Target repeats.
